prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 183 ++++++++++++++++++
 tb/tb_prog_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Streams a NUM_CORES*PROG_WORDS program image from memory into
//            per-core instruction memories, derives each core's program
//            length from its trailing zero words, then releases the cores.
// Revision : 1.0  initial release
// ============================================================================
module prog_loader #(
  parameter int NUM_CORES  = 12,
  parameter int PROG_WORDS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        mem_rd,
  output logic [7:0]  mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        core_we,
  output logic [3:0]  core_sel,
  output logic [3:0]  core_waddr,
  output logic [15:0] core_wdata,
  output logic        plen_we,
  output logic [3:0]  plen_sel,
  output logic [3:0]  plen,
  output logic        cores_run,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic [7:0] LAST_K    = 8'(NUM_CORES * PROG_WORDS - 1);
  localparam logic [3:0] LAST_SLOT = 4'(PROG_WORDS - 1);

  // Read side: state, flat word counter and its core/slot decomposition
  // (kept as separate counters so no divider is needed).
  logic [1:0]  state_q, state_d;
  logic [7:0]  k_q, k_d;
  logic [3:0]  rd_core_q, rd_core_d;
  logic [3:0]  rd_slot_q, rd_slot_d;
  // Write side: one cycle behind the read, aligned with mem_rdata.
  logic        wr_vld_q, wr_vld_d;
  logic [3:0]  wr_sel_q, wr_sel_d;
  logic [3:0]  wr_slot_q, wr_slot_d;
  // Running program length of the core currently being written.
  logic [3:0]  acc_q, acc_d;
  logic [3:0]  acc_new;
  // Program-length stage: one cycle behind the last write of a core.
  logic        plen_vld_q, plen_vld_d;
  logic [3:0]  plen_sel_q, plen_sel_d;
  logic [3:0]  plen_val_q, plen_val_d;
  logic        done_q, done_d;

  // Next-state logic for the sequencer and the write/plen pipeline.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    rd_core_d  = rd_core_q;
    rd_slot_d  = rd_slot_q;
    wr_vld_d   = 1'b0;
    wr_sel_d   = wr_sel_q;
    wr_slot_d  = wr_slot_q;
    acc_d      = acc_q;
    plen_vld_d = 1'b0;
    plen_sel_d = plen_sel_q;
    plen_val_d = plen_val_q;
    done_d     = 1'b0;

    // Slot 0 starts a fresh core; any nonzero word extends the length.
    acc_new = (wr_slot_q == 4'd0) ? 4'd0 : acc_q;
    if (mem_rdata != 16'h0000) begin
      acc_new = wr_slot_q + 4'd1;
    end

    case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          state_d   = S_LOAD;
          k_d       = 8'd0;
          rd_core_d = 4'd0;
          rd_slot_d = 4'd0;
        end
      end
      S_LOAD: begin
        wr_vld_d  = ~abort;
        wr_sel_d  = rd_core_q;
        wr_slot_d = rd_slot_q;
        if (abort) begin
          state_d = S_IDLE;
          k_d     = 8'd0;
        end else if (k_q == LAST_K) begin
          state_d = S_FLUSH;
          k_d     = 8'd0;
        end else begin
          k_d = k_q + 8'd1;
          if (rd_slot_q == LAST_SLOT) begin
            rd_slot_d = 4'd0;
            rd_core_d = rd_core_q + 4'd1;
          end else begin
            rd_slot_d = rd_slot_q + 4'd1;
          end
        end
      end
      S_FLUSH: begin
        // k doubles as the two-cycle drain counter here.
        if (abort) begin
          state_d = S_IDLE;
          k_d     = 8'd0;
        end else if (k_q[0]) begin
          state_d = S_RUN;
          k_d     = 8'd0;
          done_d  = 1'b1;
        end else begin
          k_d = 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_vld_q) begin
      acc_d = acc_new;
      if (wr_slot_q == LAST_SLOT) begin
        plen_vld_d = ~abort;
        plen_sel_d = wr_sel_q;
        plen_val_d = acc_new;
      end
    end
  end

  // State registers; reset drops any in-flight write or plen strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= 8'd0;
      rd_core_q  <= 4'd0;
      rd_slot_q  <= 4'd0;
      wr_vld_q   <= 1'b0;
      wr_sel_q   <= 4'd0;
      wr_slot_q  <= 4'd0;
      acc_q      <= 4'd0;
      plen_vld_q <= 1'b0;
      plen_sel_q <= 4'd0;
      plen_val_q <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      rd_core_q  <= rd_core_d;
      rd_slot_q  <= rd_slot_d;
      wr_vld_q   <= wr_vld_d;
      wr_sel_q   <= wr_sel_d;
      wr_slot_q  <= wr_slot_d;
      acc_q      <= acc_d;
      plen_vld_q <= plen_vld_d;
      plen_sel_q <= plen_sel_d;
      plen_val_q <= plen_val_d;
      done_q     <= done_d;
    end
  end

  // Outputs: strobes from state, data/address forced to 0 when not strobed.
  always_comb begin
    mem_rd     = (state_q == S_LOAD);
    mem_addr   = mem_rd ? k_q : 8'd0;
    core_we    = wr_vld_q;
    core_sel   = wr_vld_q ? wr_sel_q : 4'd0;
    core_waddr = wr_vld_q ? wr_slot_q : 4'd0;
    core_wdata = wr_vld_q ? mem_rdata : 16'h0000;
    plen_we    = plen_vld_q;
    plen_sel   = plen_vld_q ? plen_sel_q : 4'd0;
    plen       = plen_vld_q ? plen_val_q : 4'd0;
    busy       = (state_q == S_LOAD) || (state_q == S_FLUSH);
    cores_run  = (state_q == S_RUN);
    done       = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Randomized self-checking bench for prog_loader against a
//            cycle-offset reference model of the load timeline.
// Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;

  localparam int NC  = 12;
  localparam int PW  = 15;
  localparam int IMG = NC * PW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        core_we;
  logic [3:0]  core_sel, core_waddr;
  logic [15:0] core_wdata;
  logic        plen_we;
  logic [3:0]  plen_sel, plen;
  logic        cores_run, busy, done;

  logic [15:0] img [0:IMG-1];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mode   = 0;   // 0 idle, 1 loading, 2 running
  int t0     = 0;   // cycle in which the current load's start was sampled
  int coinc  = 0;

  prog_loader #(.NUM_CORES(NC), .PROG_WORDS(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .core_we(core_we), .core_sel(core_sel), .core_waddr(core_waddr),
    .core_wdata(core_wdata), .plen_we(plen_we), .plen_sel(plen_sel),
    .plen(plen), .cores_run(cores_run), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Image memory: data one cycle after the read, junk otherwise.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= img[mem_addr];
    else        mem_rdata <= 16'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int calc_plen(input int c);
    int p = 0;
    for (int s = 0; s < PW; s++) if (img[c*PW+s] != 16'h0000) p = s + 1;
    return p;
  endfunction

  task automatic compare();
    int rel, w, c;
    int e_rd, e_addr, e_we, e_sel, e_waddr, e_wdata;
    int e_pwe, e_psel, e_plen, e_busy, e_run, e_done;
    e_rd = 0; e_addr = 0; e_we = 0; e_sel = 0; e_waddr = 0; e_wdata = 0;
    e_pwe = 0; e_psel = 0; e_plen = 0; e_busy = 0; e_run = 0; e_done = 0;
    rel = cyc - t0;
    if (mode == 1) begin
      e_busy = 1;
      if (rel >= 1 && rel <= IMG) begin e_rd = 1; e_addr = rel - 1; end
      if (rel >= 2 && rel <= IMG + 1) begin
        w = rel - 2;
        e_we = 1; e_sel = w / PW; e_waddr = w % PW; e_wdata = int'(img[w]);
      end
      if (rel >= PW + 2 && (rel - PW - 2) % PW == 0) begin
        c = (rel - PW - 2) / PW;
        if (c < NC) begin e_pwe = 1; e_psel = c; e_plen = calc_plen(c); end
      end
    end else if (mode == 2) begin
      e_run  = 1;
      e_done = (rel == IMG + 3) ? 1 : 0;
    end
    if (core_we && plen_we) coinc++;
    check("mem_rd",     32'(mem_rd),     32'(e_rd));
    check("mem_addr",   32'(mem_addr),   32'(e_addr));
    check("core_we",    32'(core_we),    32'(e_we));
    check("core_sel",   32'(core_sel),   32'(e_sel));
    check("core_waddr", 32'(core_waddr), 32'(e_waddr));
    check("core_wdata", 32'(core_wdata), 32'(e_wdata));
    check("plen_we",    32'(plen_we),    32'(e_pwe));
    check("plen_sel",   32'(plen_sel),   32'(e_psel));
    check("plen",       32'(plen),       32'(e_plen));
    check("busy",       32'(busy),       32'(e_busy));
    check("cores_run",  32'(cores_run),  32'(e_run));
    check("done",       32'(done),       32'(e_done));
  endtask

  // One clock: apply the sampled inputs to the model, then check outputs.
  task automatic step();
    @(posedge clk);
    if (rst) mode = 0;
    else begin
      case (mode)
        0, 2: if (start) begin mode = 1; t0 = cyc; end
        default: begin
          if (abort) mode = 0;
          else if (cyc - t0 == IMG + 2) mode = 2;
        end
      endcase
    end
    cyc++;
    #1;
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic rand_image();
    for (int i = 0; i < IMG; i++)
      img[i] = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
    // Occasionally blank a whole core or keep only its last slot.
    for (int c = 0; c < NC; c++) begin
      int r = int'($urandom_range(0, 5));
      if (r == 0) for (int s = 0; s < PW; s++) img[c*PW+s] = 16'h0000;
      if (r == 1) for (int s = 0; s < PW - 1; s++) img[c*PW+s] = 16'h0000;
    end
  endtask

  initial begin
    for (int i = 0; i < IMG; i++) img[i] = 16'(16'h1000 + i);
    // Reset state
    steps(3);
    rst = 1'b0;
    steps(3);

    // Ramp image: every core full length, done at T+183
    coinc = 0;
    pulse_start();
    steps(IMG + 8);
    check("coincide_cnt", 32'(coinc), 32'(NC - 1));
    abort = 1'b1; steps(2); abort = 1'b0;   // abort in RUN is ignored

    // Directed plen patterns on cores 0..2, random elsewhere
    rand_image();
    for (int s = 0; s < PW; s++) begin
      img[s]        = (s < 4) ? 16'(16'hA000 + s) : 16'h0000;
      img[PW+s]     = 16'h0000;
      img[2*PW+s]   = (s == PW - 1) ? 16'h00FF : 16'h0000;
    end
    pulse_start();
    steps(IMG + 5);

    // Abort at T+50
    rand_image();
    pulse_start();
    steps(49);
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    steps(20);
    abort = 1'b1; steps(2); abort = 1'b0;   // abort in IDLE is ignored

    // Asynchronous reset at T+100, then a full reload
    pulse_start();
    steps(99);
    #2;
    rst = 1'b1;
    #1;
    mode = 0;
    compare();
    steps(2);
    rst = 1'b0;
    steps(5);
    rand_image();
    pulse_start();
    steps(IMG + 5);

    // start held through a load, then a second start pulse while running
    rand_image();
    start = 1'b1;
    steps(150);
    start = 1'b0;
    steps(40);
    pulse_start();
    steps(IMG + 6);

    // Random start/abort traffic
    rand_image();
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 99) < 3);
      abort = ($urandom_range(0, 999) < 4);
      step();
    end
    start = 1'b0; abort = 1'b0;
    steps(IMG + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
